// File: rtl/ntt_pkg.sv
// Shared widths, coefficient type and controller states for the 8-point inverse NTT engine.
package ntt_pkg;

   localparam int DATA_W = 8;
   localparam int N      = 8;
   localparam int LOG_N  = 3;
   localparam int N_TW   = N / 2;

   typedef logic [DATA_W-1:0] coeff_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BFLY  = 2'd1,
      SCALE = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/intt_gs_butterfly.sv
// Combinational Gentleman-Sande butterfly: a' = a+b, b' = (a-b)*w, all reduced by mod.
module intt_gs_butterfly
   import ntt_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] w,
   input  logic [DATA_W-1:0] mod,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out
);

   logic [DATA_W:0]     sum;
   logic [DATA_W:0]     diff;
   logic [2*DATA_W:0]   prod;
   logic [DATA_W:0]     sum_red;
   logic [2*DATA_W:0]   prod_red;

   // Adding mod before subtracting keeps the difference non-negative in 9 bits.
   assign sum      = {1'b0, a} + {1'b0, b};
   assign diff     = {1'b0, a} + {1'b0, mod} - {1'b0, b};
   assign prod     = (2*DATA_W+1)'(diff) * (2*DATA_W+1)'(w);
   assign sum_red  = sum % {1'b0, mod};
   assign prod_red = prod % (2*DATA_W+1)'(mod);

   assign a_out = sum_red[DATA_W-1:0];
   assign b_out = prod_red[DATA_W-1:0];

endmodule

// File: rtl/intt_8point_engine.sv
// 8-point inverse NTT: latches a bundle, runs 12 in-place GS butterflies, scales by n_inv,
// then holds the result until the consumer accepts it.
//
// state | meaning
// IDLE  | waiting for a bundle, in_ready high
// BFLY  | one butterfly per cycle, 3 stages x 4 pairs
// SCALE | one element multiplied by n_inv per cycle
// DONE  | result presented, waiting for out_ready
module intt_8point_engine
   import ntt_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [N-1:0][DATA_W-1:0]      data_in,
   input  logic [N_TW-1:0][DATA_W-1:0]   omegas_inv,
   input  logic [DATA_W-1:0]             n_inv,
   input  logic [DATA_W-1:0]             mod,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [N-1:0][DATA_W-1:0]      data_out,
   output logic                          busy
);

   state_t                        state_q, state_d;
   logic [1:0]                    stage_q, pair_q;
   logic [LOG_N-1:0]              scale_idx_q;
   logic [N-1:0][DATA_W-1:0]      x_q;
   logic [N_TW-1:0][DATA_W-1:0]   om_q;
   logic [DATA_W-1:0]             n_inv_q, mod_q;
   logic                          out_valid_q;
   logic [N-1:0][DATA_W-1:0]      data_out_q;

   logic [LOG_N-1:0]              idx_a, idx_b;
   logic [DATA_W-1:0]             tw, bf_a_out, bf_b_out, scaled;
   logic [2*DATA_W-1:0]           scale_prod, scale_red;
   logic                          bfly_last, scale_last;

   assign bfly_last  = (stage_q == 2'd2) && (pair_q == 2'd3);
   assign scale_last = (scale_idx_q == LOG_N'(N-1));

   // Pair addressing: distance 4, then 2, then 1 between butterfly operands.
   always_comb begin
      idx_a = '0;
      idx_b = '0;
      tw    = om_q[0];
      case (stage_q)
         2'd0: begin
            idx_a = {1'b0, pair_q};
            idx_b = {1'b1, pair_q};
            tw    = om_q[pair_q];
         end
         2'd1: begin
            idx_a = {pair_q[1], 1'b0, pair_q[0]};
            idx_b = {pair_q[1], 1'b1, pair_q[0]};
            tw    = om_q[{pair_q[0], 1'b0}];
         end
         default: begin
            idx_a = {pair_q, 1'b0};
            idx_b = {pair_q, 1'b1};
            tw    = om_q[0];
         end
      endcase
   end

   intt_gs_butterfly u_bfly (
      .a     (x_q[idx_a]),
      .b     (x_q[idx_b]),
      .w     (tw),
      .mod   (mod_q),
      .a_out (bf_a_out),
      .b_out (bf_b_out)
   );

   assign scale_prod = (2*DATA_W)'(x_q[scale_idx_q]) * (2*DATA_W)'(n_inv_q);
   assign scale_red  = scale_prod % (2*DATA_W)'(mod_q);
   assign scaled     = scale_red[DATA_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = BFLY;
         end
         BFLY: begin
            busy = 1'b1;
            if (bfly_last) state_d = SCALE;
         end
         SCALE: begin
            busy = 1'b1;
            if (scale_last) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q     <= '0;
         pair_q      <= '0;
         scale_idx_q <= '0;
         x_q         <= '0;
         om_q        <= '0;
         n_inv_q     <= '0;
         mod_q       <= '0;
         out_valid_q <= 1'b0;
         data_out_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  x_q         <= data_in;
                  om_q        <= omegas_inv;
                  n_inv_q     <= n_inv;
                  mod_q       <= mod;
                  stage_q     <= '0;
                  pair_q      <= '0;
                  scale_idx_q <= '0;
               end
            end
            BFLY: begin
               x_q[idx_a] <= bf_a_out;
               x_q[idx_b] <= bf_b_out;
               pair_q     <= pair_q + 2'd1;
               if (bfly_last)           stage_q <= '0;
               else if (pair_q == 2'd3) stage_q <= stage_q + 2'd1;
            end
            SCALE: begin
               x_q[scale_idx_q] <= scaled;
               scale_idx_q      <= scale_idx_q + LOG_N'(1);
               // The last scaled element bypasses x_q so the result is complete on entry to DONE.
               if (scale_last) begin
                  out_valid_q        <= 1'b1;
                  data_out_q         <= x_q;
                  data_out_q[N-1]    <= scaled;
               end
            end
            DONE: begin
               if (out_ready) out_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign data_out  = data_out_q;

endmodule

// File: doc/intt_8point_engine.md
INTT_8POINT_ENGINE -- requirements
Module: intt_8point_engine

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  input bundle valid.
REQ-005 in_ready  output  1  engine can accept a bundle.
REQ-006 data_in  input  8x8  NTT-domain coefficients [7:0], each < mod.
REQ-007 omegas_inv  input  4x8  inverse twiddles w^-0..w^-3 mod mod.
REQ-008 n_inv  input  8  8^-1 mod mod.
REQ-009 mod  input  8  modulus, 2..255.
REQ-010 out_valid  output  1  result bundle valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 data_out  output  8x8  time-domain coefficients [7:0], each < mod.
REQ-013 busy  output  1  high in BFLY or SCALE.

Function
REQ-014 FSM states SHALL be IDLE, BFLY, SCALE, DONE.
REQ-015 in_ready SHALL equal (state==IDLE); in_valid outside IDLE is ignored.
REQ-016 On in_valid&&in_ready at edge T, data_in, omegas_inv, n_inv and mod SHALL be latched into internal registers and the FSM moves to BFLY.
REQ-017 BFLY SHALL run 12 cycles, one Gentleman-Sande butterfly per cycle: stage counter 0..2, pair index 0..3.
REQ-018 Stage 0 pairs (j,j+4), j=0..3, twiddle omegas_inv[j].
REQ-019 Stage 1 pairs (j,j+2), j in {0,1,4,5}, twiddle omegas_inv[2*(j%2)].
REQ-020 Stage 2 pairs (j,j+1), j in {0,2,4,6}, twiddle omegas_inv[0].
REQ-021 Butterfly: a' = (a+b) mod mod (9-bit sum); b' = ((a-b+mod) * w) mod mod (9-bit difference, 17-bit product); both written in place the same cycle.
REQ-022 SCALE SHALL run 8 cycles, element k on cycle k: x[k] = (x[k]*n_inv) mod mod (16-bit product).
REQ-023 After SCALE, FSM enters DONE; out_valid SHALL assert first at cycle T+20 and data_out SHALL show the register file.
REQ-024 In DONE, out_valid and data_out SHALL hold stable until out_ready is high; on that edge FSM returns to IDLE and out_valid drops the next cycle.
REQ-025 out_ready outside DONE SHALL have no effect; no overlap of bundles (throughput one per >=21 cycles).
REQ-026 Outputs SHALL be fully registered; no combinational path from any input to any output except via state.
REQ-027 Result SHALL exactly invert the team's 8-point Cooley-Tukey forward network, given matching twiddles.

Reset
REQ-028 rst high SHALL force state=IDLE, counters=0, out_valid=0, busy=0, data_out=0, in_ready=1 after reset release.
REQ-029 rst mid-BFLY/SCALE/DONE SHALL discard the bundle in flight; no partial result ever reaches out_valid.

Structure
REQ-030 Package ntt_pkg SHALL hold DATA_W=8, N=8, LOG_N=3, coefficient typedef, and FSM state enum.
REQ-031 One sub-module intt_gs_butterfly (combinational a,b,w,mod -> a',b') SHALL be instantiated once.

Verification
REQ-032 mod=17, omegas_inv={1,9,13,15}, n_inv=15, data_in all 3 -> data_out {3,0,0,0,0,0,0,0}, out_valid at T+20.
REQ-033 Same params, data_in {1,0,0,0,0,0,0,0} -> data_out all 15.
REQ-034 Same params, data_in all 16 (mod-1 boundary) -> data_out {16,0,0,0,0,0,0,0}, no overflow.
REQ-035 out_ready held low 5 cycles in DONE -> out_valid/data_out stable all 5; in_valid pulses during BFLY ignored (in_ready=0).
REQ-036 rst asserted at T+6 -> out_valid stays 0, in_ready=1 after release; next bundle yields correct result.
REQ-037 Random round-trip, mod=17: forward network output fed in -> data_out equals original input, 200 vectors.
